// File: rtl/strided_line_buffer_array_pkg.sv
// Shared types and size helpers for the strided sliding-window generator.
// The PE array controller imports the same derived-size functions.
package strided_line_buffer_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int padded_dim(input int n, input int pad);
    return n + 2 * pad;
  endfunction

  function automatic int out_dim(input int np, input int k, input int stride);
    return (np - k) / stride + 1;
  endfunction

  // Flat element index of channel i, window row kr, window column kc.
  function automatic int win_idx(input int i, input int kr, input int kc,
                                 input int kh, input int kw);
    return (i * kh + kr) * kw + kc;
  endfunction

endpackage

// File: rtl/strided_line_buffer_array_row.sv
// One padded image row of pixel history: a DEPTH-deep shift register, advanced on i_en.
// Zero latency to the tap; no flow control of its own, the parent gates i_en.
module strided_line_buffer_array_row #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/strided_line_buffer_array.sv
// Streams a raster feature map, inserts zero padding itself and emits strided Kh x Kw x Nin windows.
// Window registered one cycle after its last pixel steps in; any step that would emit stalls while the output slot is full.
module strided_line_buffer_array
  import strided_line_buffer_array_pkg::*;
#(
  parameter int Kh        = 3,
  parameter int Kw        = 3,
  parameter int h         = 5,
  parameter int w         = 5,
  parameter int Nin       = 3,
  parameter int pad_h     = 1,
  parameter int pad_w     = 1,
  parameter int STRIDE    = 1,
  parameter int BIT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [Nin*BIT_WIDTH-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [Nin*Kh*Kw*BIT_WIDTH-1:0] out_data,
  output logic                           out_last
);

  localparam int Hp     = padded_dim(h, pad_h);
  localparam int Wp     = padded_dim(w, pad_w);
  localparam int RW     = clog2_min1(Hp);
  localparam int CW     = clog2_min1(Wp);
  localparam int PW     = Nin * BIT_WIDTH;
  localparam int LAST_R = Hp - 1 - ((Hp - Kh) % STRIDE);
  localparam int LAST_C = Wp - 1 - ((Wp - Kw) % STRIDE);

  if (Hp < Kh || Wp < Kw || STRIDE < 1 || Kh < 2 || Kw < 1) begin : g_bad_cfg
    $error("strided_line_buffer_array: kernel larger than padded map, or bad stride");
  end

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  int              w_ri, w_ci;
  logic            w_interior, w_emit, w_at_last_win, w_at_end;
  logic            w_slot_free, w_slot_ok, w_fire, w_done_nxt;
  logic            r_out_vld, r_out_last, r_done;
  logic [PW-1:0]   w_pix;
  logic [Kh-1:0][PW-1:0] w_chain;
  logic [PW-1:0]   r_win     [Kh][Kw];
  logic [PW-1:0]   w_win_nxt [Kh][Kw];
  logic [PW-1:0]   r_out_win [Kh][Kw];

  always_comb begin
    w_ri          = int'(r_row);
    w_ci          = int'(r_col);
    w_interior    = (w_ri >= pad_h) && (w_ri < pad_h + h) &&
                    (w_ci >= pad_w) && (w_ci < pad_w + w);
    w_emit        = (w_ri >= Kh - 1) && (w_ci >= Kw - 1) &&
                    (((w_ri - (Kh - 1)) % STRIDE) == 0) &&
                    (((w_ci - (Kw - 1)) % STRIDE) == 0);
    w_at_last_win = (w_ri == LAST_R) && (w_ci == LAST_C);
    w_at_end      = (w_ri == Hp - 1) && (w_ci == Wp - 1);
    w_pix         = w_interior ? in_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    in_ready    = 1'b0;
    w_done_nxt  = 1'b0;
    w_slot_free = !r_out_vld || out_ready;
    w_slot_ok   = !w_emit || w_slot_free;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = w_interior && w_slot_ok;
        w_fire   = w_slot_ok && (!w_interior || in_valid);
        if (w_fire && w_at_end) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_slot_free) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // w_chain[k] is the pixel k padded rows above the one entering now.
  assign w_chain[0] = w_pix;
  for (genvar k = 0; k < Kh - 1; k++) begin : g_row
    strided_line_buffer_array_row #(
      .DEPTH(Wp),
      .WIDTH(PW)
    ) u_row (
      .clk   (clk),
      .i_en  (w_fire),
      .i_din (w_chain[k]),
      .o_dout(w_chain[k+1])
    );
  end

  always_comb begin
    for (int kr = 0; kr < Kh; kr++) begin
      for (int kc = 0; kc < Kw - 1; kc++) begin
        w_win_nxt[kr][kc] = r_win[kr][kc+1];
      end
      w_win_nxt[kr][Kw-1] = w_chain[Kh-1-kr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_win <= w_win_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
      for (int kr = 0; kr < Kh; kr++) begin
        for (int kc = 0; kc < Kw; kc++) begin
          r_out_win[kr][kc] <= '0;
        end
      end
    end else begin
      r_done <= w_done_nxt;
      if (r_state == ST_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_fire) begin
        if (w_ci == Wp - 1) begin
          r_col <= '0;
          r_row <= (w_ri == Hp - 1) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // The window register keeps shifting on padding steps, so the output copy is separate.
      if (w_fire && w_emit) begin
        r_out_win  <= w_win_nxt;
        r_out_vld  <= 1'b1;
        r_out_last <= w_at_last_win;
      end else if (out_ready) begin
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < Nin; i++) begin
      for (int kr = 0; kr < Kh; kr++) begin
        for (int kc = 0; kc < Kw; kc++) begin
          out_data[win_idx(i, kr, kc, Kh, Kw)*BIT_WIDTH +: BIT_WIDTH] =
            r_out_win[kr][kc][i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = r_done;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_strided_line_buffer_array.sv
// Directed bench: stride 1 and stride 2 instances on a 5x5x3 map with pad 1, 3x3 kernel.
// Covers reset, full frames, backpressure, input bubbles and reset mid-frame.
module tb_strided_line_buffer_array;

  localparam int BW  = 8;
  localparam int NIN = 3;
  localparam int PW  = NIN * BW;
  localparam int OW  = NIN * 3 * 3 * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b, in_valid, out_ready, sel;
  logic [PW-1:0] in_data;
  logic          a_busy, a_done, a_in_ready, a_out_valid, a_out_last;
  logic          b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
  logic [OW-1:0] a_out_data, b_out_data;
  logic          m_busy, m_done, m_in_ready, m_out_valid, m_out_last;
  logic [OW-1:0] m_out_data;

  strided_line_buffer_array u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  strided_line_buffer_array #(.STRIDE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_last  = sel ? b_out_last  : a_out_last;
  assign m_out_data  = sel ? b_out_data  : a_out_data;

  int checks = 0;
  int fails  = 0;

  task automatic check_val(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  int          s2_centre [9] = '{1, 3, 5, 11, 13, 15, 21, 23, 25};
  logic [71:0] first_ch0 = {8'd7, 8'd6, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

  logic [OW-1:0] exp_dat [$];
  bit            exp_last [$];

  function automatic logic [PW-1:0] mkpix(input int v);
    return {8'(v + 128), 8'(v + 64), 8'(v)};
  endfunction

  // Window whose bottom-right corner is padded position (pr_br, pc_br).
  function automatic logic [OW-1:0] model_win(input int pr_br, input int pc_br);
    logic [OW-1:0] wv;
    logic [PW-1:0] px;
    int pr, pc;
    wv = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        pr = pr_br - 2 + kr;
        pc = pc_br - 2 + kc;
        if (pr >= 1 && pr <= 5 && pc >= 1 && pc <= 5) px = mkpix((pr - 1) * 5 + pc);
        else px = '0;
        for (int i = 0; i < NIN; i++) wv[((i * 3 + kr) * 3 + kc) * BW +: BW] = px[i * BW +: BW];
      end
    end
    return wv;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_busy"}, m_busy, 0);
    check_val({pfx, "_done"}, m_done, 0);
    check_val({pfx, "_in_ready"}, m_in_ready, 0);
    check_val({pfx, "_out_valid"}, m_out_valid, 0);
    check_val({pfx, "_out_last"}, m_out_last, 0);
    check_val({pfx, "_out_data"}, m_out_data, 0);
  endtask

  // mode: 0 plain, 1 random out_ready, 2 input bubbles, 3 reset at pixel 12
  task automatic run_frame(input bit use_b, input int mode);
    int s, p, nwin, cyc, last_cyc, pad_cyc, cen;
    bit got_done, held;
    logic [OW-1:0] held_dat;
    s = use_b ? 2 : 1;
    p = 0; nwin = 0; last_cyc = -10; pad_cyc = 0; got_done = 0; held = 0; held_dat = '0;
    exp_dat.delete();
    exp_last.delete();
    for (int pr = 0; pr < 7; pr++) begin
      for (int pc = 0; pc < 7; pc++) begin
        if (pr >= 2 && pc >= 2 && (pr - 2) % s == 0 && (pc - 2) % s == 0) begin
          exp_dat.push_back(model_win(pr, pc));
          exp_last.push_back(pr == 6 - (4 % s) && pc == 6 - (4 % s));
        end
      end
    end
    sel = use_b;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (cyc = 0; cyc < 1000 && !got_done; cyc++) begin
      in_valid  = (mode == 2) ? ((cyc % 7) < 4) : 1'b1;
      in_data   = mkpix(p + 1);
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held && m_out_valid) check_val("hold_data", m_out_data, held_dat);
      held     = m_out_valid && !out_ready;
      held_dat = m_out_data;
      if (m_busy && !m_in_ready) pad_cyc++;
      if (m_done) begin
        check_val("done_latency", cyc - last_cyc, 1);
        got_done = 1;
      end
      if (in_valid && m_in_ready) p++;
      if (m_out_valid && out_ready) begin
        if (nwin < exp_dat.size()) begin
          check_val("win_data", m_out_data, exp_dat[nwin]);
          check_val("win_last", m_out_last, exp_last[nwin]);
          if (use_b) cen = s2_centre[nwin]; else cen = nwin + 1;
          check_val("centre_ch0", m_out_data[4*BW +: BW], cen);
          check_val("centre_ch2", m_out_data[22*BW +: BW], cen + 128);
          if (nwin == 0) check_val("first_win_ch0", m_out_data[71:0], first_ch0);
        end else begin
          check_val("extra_win", nwin, exp_dat.size() - 1);
        end
        if (m_out_last) last_cyc = cyc;
        nwin++;
      end
      if (mode == 3 && p == 12) break;
      @(posedge clk); #1;
    end
    if (mode == 3) begin
      #2 rst = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    check_val("done_seen", got_done, 1);
    check_val("win_count", nwin, exp_dat.size());
    check_val("pixel_count", p, 25);
    // 24 padding steps plus the single DRAIN cycle
    if (use_b && mode == 0) check_val("pad_cycles", pad_cyc, 25);
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #3 check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rst = 1'b1;
    run_frame(1'b0, 0);
    run_frame(1'b1, 0);
    run_frame(1'b0, 1);
    run_frame(1'b0, 2);
    run_frame(1'b0, 3);
    run_frame(1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
